// File: rtl/pio_poll_ctrl.sv
// Polled PIO input debouncer: samples a PIO port every PERIOD+2 cycles, accepts a
// value after DEB_COUNT equal samples and latches changed bits into a W1C EDGE register.
module pio_poll_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEB_COUNT  = 3,
  parameter int unsigned PERIOD_RST = 1000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned MATCH_W = 4;
  localparam int unsigned DATA_W  = 32;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_STABLE = 2'd2;
  localparam logic [1:0] ADDR_EDGE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SAMPLE = 2'd2,
    UPDATE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [WIDTH-1:0]   sample_q, sample_d;
  logic [WIDTH-1:0]   cand_q, cand_d;
  logic [WIDTH-1:0]   stable_q, stable_d;
  logic [WIDTH-1:0]   edge_q, edge_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               irq_q, irq_d;
  logic [1:0]         pio_addr_q;

  logic [WIDTH-1:0]   new_edge;
  logic [WIDTH-1:0]   edge_clr;
  logic               accept;

  logic unused_ok;
  assign unused_ok = ^{pio_readdata, avs_writedata};

  // State and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= CNT_W'(PERIOD_RST);
      ctrl_q     <= '0;
      sample_q   <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      edge_q     <= '0;
      match_q    <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      pio_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      ctrl_q     <= ctrl_d;
      sample_q   <= sample_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      edge_q     <= edge_d;
      match_q    <= match_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      pio_addr_q <= 2'b00;
    end
  end

  // Polling FSM, debounce, acceptance and CPU register access
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    ctrl_d   = ctrl_q;
    sample_d = sample_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    match_d  = match_q;
    rdata_d  = rdata_q;
    new_edge = '0;
    edge_clr = '0;

    // Acceptance looks at the post-update count, i.e. the cycle after UPDATE
    accept = (match_q == MATCH_W'(DEB_COUNT)) && (cand_q != stable_q);
    if (accept) begin
      stable_d = cand_q;
      new_edge = stable_q ^ cand_q;
    end

    case (state_q)
      IDLE: begin
        if (ctrl_q[0]) begin
          state_d = COUNT;
          cnt_d   = period_q;
        end
      end
      COUNT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = SAMPLE;
      end
      SAMPLE: begin
        sample_d = pio_readdata[WIDTH-1:0];
        state_d  = UPDATE;
      end
      UPDATE: begin
        if (sample_q == cand_q) begin
          if (match_q != MATCH_W'(DEB_COUNT)) match_d = match_q + MATCH_W'(1);
        end else begin
          cand_d  = sample_q;
          match_d = MATCH_W'(1);
        end
        cnt_d   = period_q;
        state_d = COUNT;
      end
      default: state_d = IDLE;
    endcase

    if (!ctrl_q[0]) begin
      state_d = IDLE;
      match_d = '0;
    end

    if (avs_write) begin
      case (avs_address)
        ADDR_CTRL:   ctrl_d   = avs_writedata[1:0];
        ADDR_PERIOD: period_d = (avs_writedata[15:0] == 16'd0) ? CNT_W'(1) : avs_writedata[15:0];
        ADDR_EDGE:   edge_clr = avs_writedata[WIDTH-1:0];
        default:     ;
      endcase
    end

    // A same-cycle set beats the W1C clear
    edge_d = (edge_q & ~edge_clr) | new_edge;

    if (avs_read) begin
      case (avs_address)
        ADDR_CTRL:   rdata_d = DATA_W'(ctrl_q);
        ADDR_PERIOD: rdata_d = DATA_W'(period_q);
        ADDR_STABLE: rdata_d = DATA_W'(stable_q);
        ADDR_EDGE:   rdata_d = DATA_W'(edge_q);
        default:     rdata_d = '0;
      endcase
    end

    irq_d = ctrl_d[1] & (|edge_d);
  end

  assign pio_address  = pio_addr_q;
  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule
